ctrl_accel_seq: RTL
===================

Name: ctrl_accel_seq

Overview:
- Multi-cycle successor to the CPU opcode control decoder.
- Decodes the datapath controls Branch, MemWrite, MemToReg, RegWrite and ALUSrc as registered one-cycle strobes.
- Generalises the hash/encrypt/decrypt triggers to NUM_ACC accelerator channels with a start/done handshake.
- Stalls the CPU front end while an accelerator runs; latches HALT.

Parameters:
OPW, 5, opcode width (minimum 5); decode uses opcode[OPW-1 -: 5]; lower bits ignored
NUM_ACC, 3, number of accelerator channels (1..4)
ACC_BASE, 5'b11100, channel k is selected by top-5 opcode == ACC_BASE+k, k < NUM_ACC
HALT_OP, 5'b11111, halt opcode
TO_CYC, 1024, accelerator timeout in cycles (used only with ACCEL_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPW  instruction opcode
op_valid  in  1  opcode valid this cycle
Branch  out  1  branch strobe
MemWrite  out  1  memory write strobe
MemToReg  out  1  writeback from memory strobe
RegWrite  out  1  register write strobe
ALUSrc  out  1  1 = immediate, 0 = RT
acc_start  out  NUM_ACC  one-hot start pulse per channel
acc_done  in  NUM_ACC  per-channel completion, level or pulse
stall  out  1  front end must hold; op_valid is ignored while high
halted  out  1  HALT reached
acc_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0. All outputs 0, including acc_err and halted.
- States: IDLE, ISSUE, WAIT, HALT. stall = (state != IDLE). halted = (state == HALT).
- An op is accepted only when state == IDLE and op_valid == 1 (cycle N). Let t = opcode[OPW-1 -: 5].
- Non-accelerator, non-halt op: in cycle N+1 the control outputs are driven for exactly one cycle; they are 0 otherwise. State stays IDLE, so back-to-back ops give one strobe set per cycle.
  - Branch = (t[4:3] == 2'b10).
  - MemToReg = (t == 01101).
  - MemWrite = (t == 01100).
  - RegWrite = 0 for 00000, 01100, 10xxx, 11xxx; 1 otherwise.
  - ALUSrc = 0 for 00110 and 00111; 1 otherwise.
- Accelerator op, channel k:
  - Cycle N+1: state ISSUE, acc_start[k]=1 for exactly that cycle; all five control outputs 0.
  - Cycle N+2 onward: state WAIT.
  - acc_done[k] sampled high in ISSUE or WAIT -> IDLE next cycle. stall low from that cycle; a new op can be accepted the same cycle.
  - acc_done on any other channel is ignored. acc_done high in IDLE is ignored.
- t in the ACC_BASE range but k >= NUM_ACC: treated as NOP, all strobes 0, stays IDLE.
- HALT_OP accepted: HALT from cycle N+1; stall=1 and halted=1 until reset. No strobes are issued.
- HALT_OP takes priority if it overlaps the ACC_BASE range.
- Only one accelerator is outstanding at a time; acc_start is always one-hot or zero.
- Reset mid-operation: immediate return to reset values. acc_start is never re-issued after reset.

Optional Feature:
ACCEL_TIMEOUT_EN
- Defined: a counter clears on entering ISSUE and increments each ISSUE/WAIT cycle without the matching done. When it reaches TO_CYC-1, the block returns to IDLE next cycle and sets acc_err=1, sticky until reset.
  - Done and timeout in the same cycle: done wins, acc_err unchanged.
- Undefined: no counter; WAIT persists until done; acc_err tied 0.

Test Plan:
- Reset with opcode=01101, op_valid=1 -> all outputs 0. Release, then N: 01101 valid -> N+1: MemToReg=1, RegWrite=1, ALUSrc=1; N+2: all 0.
- Back-to-back 10010, 00110, 01100 -> three consecutive cycles: {Branch=1, RegWrite=0}; {RegWrite=1, ALUSrc=0}; {MemWrite=1, RegWrite=0}. stall stays 0.
- Opcode 11101 -> acc_start=3'b010 for one cycle, stall=1. acc_done=3'b001 ignored. acc_done=3'b010 at cycle N+6 -> stall=0 at N+7; op 00001 accepted at N+7 gives RegWrite=1 at N+8.
- Opcode 11110, reset asserted during WAIT -> all outputs 0 immediately. Then 00000 valid -> all strobes 0, stall 0.
- Opcode 11111 -> halted=1 and stall=1 from N+1; further op_valid ignored for 20 cycles, no strobes.
- ACCEL_TIMEOUT_EN, TO_CYC=8, opcode 11100 with no done -> acc_err=1 and stall=0 after 8 busy cycles. acc_err stays 1 through a subsequent successful op.

Source files
------------

// File: rtl/ctrl_accel_seq.sv
// Opcode control decoder with one-cycle registered strobes, NUM_ACC accelerator start/done channels,
// front-end stall and latched HALT. Define ACCEL_TIMEOUT_EN to add the per-op accelerator timeout and sticky acc_err.
module ctrl_accel_seq #(
    parameter int          OPW      = 5,
    parameter int          NUM_ACC  = 3,
    parameter logic [4:0]  ACC_BASE = 5'b11100,
    parameter logic [4:0]  HALT_OP  = 5'b11111,
    parameter int          TO_CYC   = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPW-1:0]     opcode,
    input  logic               op_valid,
    output logic               Branch,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic [NUM_ACC-1:0] acc_start,
    input  logic [NUM_ACC-1:0] acc_done,
    output logic               stall,
    output logic               halted,
    output logic               acc_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

    localparam logic [5:0] NUM_ACC_W = 6'(NUM_ACC);

    state_t      state_reg, state_next;
    logic [1:0]  ch_reg, ch_next;
    logic [4:0]  ctrl_reg, ctrl_next;   // {Branch, MemWrite, MemToReg, RegWrite, ALUSrc}

    logic [4:0]  t;
    logic [5:0]  acc_diff;
    logic        in_acc_window;
    logic        acc_hit;
    logic        is_halt;
    logic        busy;
    logic        done_sel;
    logic        timeout_hit;
    logic [NUM_ACC-1:0] done_match;

    assign t        = opcode[OPW-1 -: 5];
    assign is_halt  = (t == HALT_OP);
    // The window spans the four possible channel slots; slots beyond NUM_ACC decode as NOP.
    assign acc_diff      = {1'b0, t} - {1'b0, ACC_BASE};
    assign in_acc_window = !acc_diff[5] && (acc_diff[4:2] == 3'b000);
    assign acc_hit       = in_acc_window && (acc_diff < NUM_ACC_W);
    assign busy          = (state_reg == ISSUE) || (state_reg == WAIT);

    generate
        for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_chan
            assign acc_start[gi]  = (state_reg == ISSUE) && (ch_reg == 2'(gi));
            assign done_match[gi] = acc_done[gi] && (ch_reg == 2'(gi));
        end
        if (OPW > 5) begin : g_op_lsb
            logic unused_op_lsb;
            assign unused_op_lsb = ^opcode[OPW-6:0];
        end
    endgenerate

    assign done_sel = busy && (|done_match);

`ifdef ACCEL_TIMEOUT_EN
    localparam int             CW      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt_reg;
    logic          err_reg;

    // A done arriving in the final counted cycle still completes normally.
    assign timeout_hit = busy && !done_sel && (cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && op_valid && !is_halt && acc_hit)
                cnt_reg <= '0;
            else if (busy && !done_sel)
                cnt_reg <= cnt_reg + 1'b1;
            if (timeout_hit)
                err_reg <= 1'b1;
        end
    end

    assign acc_err = err_reg;
`else
    logic unused_to;
    assign unused_to   = (TO_CYC == 0);
    assign timeout_hit = 1'b0;
    assign acc_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ch_reg    <= 2'd0;
            ctrl_reg  <= 5'd0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            ctrl_reg  <= ctrl_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        ctrl_next  = 5'd0;
        case (state_reg)
            IDLE: begin
                if (op_valid) begin
                    if (is_halt) begin
                        state_next = HALT;
                    end else if (acc_hit) begin
                        state_next = ISSUE;
                        ch_next    = acc_diff[1:0];
                    end else if (!in_acc_window) begin
                        ctrl_next[4] = (t[4:3] == 2'b10);
                        ctrl_next[3] = (t == 5'b01100);
                        ctrl_next[2] = (t == 5'b01101);
                        ctrl_next[1] = !((t == 5'b00000) || (t == 5'b01100) || t[4]);
                        ctrl_next[0] = !(t[4:1] == 4'b0011);
                    end
                end
            end
            ISSUE, WAIT: begin
                if (done_sel || timeout_hit)
                    state_next = IDLE;
                else
                    state_next = WAIT;
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign Branch   = ctrl_reg[4];
    assign MemWrite = ctrl_reg[3];
    assign MemToReg = ctrl_reg[2];
    assign RegWrite = ctrl_reg[1];
    assign ALUSrc   = ctrl_reg[0];
    assign stall    = (state_reg != IDLE);
    assign halted   = (state_reg == HALT);

endmodule
